mips_multicycle_controller: RTL
===============================

# mips_multicycle_controller

Control sequencer that runs the team's MIPS datapath in multicycle form: one shared memory for instructions and data, an instruction register, and a single ALU reused for PC increment, branch target and execution. The block holds a Moore state machine, decodes opcode and funct, and drives every enable and mux select of the multicycle datapath. It replaces the combinational Control_Unit when the core is built as a multicycle machine.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; state returns to FETCH and the sticky `illegal` flag clears.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag in the current cycle.
- pc_en  out  1  PC register load enable.
- ir_write  out  1  IR load enable.
- mem_write  out  1  shared-memory write enable.
- reg_write  out  1  register-file write enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  WD3 select: 0 = ALUOut, 1 = Data register.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky flag, set on an unsupported opcode or funct.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEX, j→JUMP.
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
  - Unused encodings 12–15 go to FETCH.
- Per-state outputs. Any output not listed is 0; alu_control defaults to 010.
  - FETCH: ir_write=1, pc_en=1, alu_src_b=01, add.
  - DECODE: alu_src_b=11, add.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, add.
  - MEMREAD: i_or_d=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWRITE: i_or_d=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
  - ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero.
  - ADDIWB: reg_write=1.
  - JUMP: pc_src=10, pc_en=1.
- Illegal instructions, both checked in DECODE:
  - Unknown opcode, or R-type with an unknown funct: `illegal` sets and the next state is FETCH.
  - No write enables are asserted for that instruction, so it executes as a NOP.
- While reset=1, all write enables (pc_en, ir_write, mem_write, reg_write) are forced to 0, independent of state.

## Timing
- Outputs are combinational from state. pc_en in BRANCH additionally depends on `zero`.
- Cycles per instruction: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.
- Reset is sampled at the clock edge. The cycle after reset deasserts is FETCH, with outputs at their FETCH values; `illegal`=0.
- Reset asserted mid-instruction aborts it. No write enable is asserted during or after that reset cycle, and the next fetch starts at FETCH.
- `illegal` updates on the edge that leaves DECODE. Once set, it holds until reset.

## Configuration
- `MIPS_MC_BNE_EN` defined: opcode 000101 (bne) is legal.
  - DECODE→BRANCH with a latched bne flag.
  - In BRANCH, pc_en = ~zero.
- Not defined: 000101 is illegal and is handled as an unknown opcode.

## Structure
- Shared package `mips_mc_pkg` holds:
  - the state encoding constants,
  - the opcode and funct constants,
  - the alu_control codes and the alu_src_b and pc_src select codes.
- One sub-module, `mc_alu_decoder`: combinational funct → alu_control plus a funct-valid flag. Its output is used only in EXECUTE.

## Test plan
- Reset held 3 cycles mid-MEMWRITE → mem_write=0 throughout the reset cycles; state=0 the cycle after release; `illegal`=0.
- lw (op=100011) → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; i_or_d=1 in state 3.
- R-type, funct=101010 → EXECUTE drives alu_control=111; ALUWB has reg_dst=1, reg_write=1; total 4 cycles.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH. With zero=0 → pc_en=0. Both return to FETCH after 3 cycles.
- op=111111 → `illegal`=1 after DECODE; next state FETCH; no reg_write, mem_write or pc_en asserted outside FETCH; the flag stays set through the next lw.
- With `MIPS_MC_BNE_EN`: bne with zero=0 → pc_en=1 in BRANCH. Without the macro: `illegal`=1.

Source files
------------

// File: rtl/mips_multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: state encoding, opcodes,
// funct codes and datapath select codes. MIPS_MC_BNE_EN adds bne to the legal opcodes.
package mips_mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MIPS_MC_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, enables and selects out.
interface mips_multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, state, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, ir_write, mem_write, reg_write, i_or_d, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, state, illegal
    );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// R-type funct decoder: ALU operation plus a flag saying the funct is supported.
module mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_valid
);
    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FUNCT_ADD: o_alu_control = ALU_ADD;
            FUNCT_SUB: o_alu_control = ALU_SUB;
            FUNCT_AND: o_alu_control = ALU_AND;
            FUNCT_OR:  o_alu_control = ALU_OR;
            FUNCT_SLT: o_alu_control = ALU_SLT;
            default:   o_funct_valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath with a sticky illegal-instruction flag.
// Defining MIPS_MC_BNE_EN makes bne legal, sharing the BRANCH state with an inverted zero test.
module mips_multicycle_controller
    import mips_mc_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_controller_if.master  bus
);
    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic       r_illegal;
    logic       w_illegal_next;
    logic [2:0] w_funct_alu;
    logic       w_funct_valid;
    logic       w_decode_illegal;
    logic       w_branch_inv;
    ctrl_t      w_ctrl;

    mc_alu_decoder u_alu_decoder (
        .i_funct       (bus.funct),
        .o_alu_control (w_funct_alu),
        .o_funct_valid (w_funct_valid)
    );

    assign w_decode_illegal = !op_supported(bus.op) ||
                              ((bus.op == OP_RTYPE) && !w_funct_valid);

`ifdef MIPS_MC_BNE_EN
    logic r_bne;
    always_ff @(posedge clk) begin
        if (reset)
            r_bne <= 1'b0;
        else if (r_state == S_DECODE)
            r_bne <= (bus.op == OP_BNE);
    end
    assign w_branch_inv = r_bne;
`else
    assign w_branch_inv = 1'b0;
`endif

    always_comb begin
        w_state_next   = S_FETCH;
        w_illegal_next = r_illegal;
        case (r_state)
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                // Illegal instructions skip straight back to FETCH: two cycles, no writes.
                if (w_decode_illegal) begin
                    w_illegal_next = 1'b1;
                end else begin
                    case (bus.op)
                        OP_LW, OP_SW: w_state_next = S_MEMADR;
                        OP_RTYPE:     w_state_next = S_EXECUTE;
                        OP_BEQ:       w_state_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                        OP_BNE:       w_state_next = S_BRANCH;
`endif
                        OP_ADDI:      w_state_next = S_ADDIEX;
                        OP_J:         w_state_next = S_JUMP;
                        default:      w_state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  w_state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_state_next = S_MEMWB;
            S_EXECUTE: w_state_next = S_ALUWB;
            S_ADDIEX:  w_state_next = S_ADDIWB;
            default:   w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_illegal <= w_illegal_next;
        end
    end

    always_comb begin
        w_ctrl             = '0;
        w_ctrl.alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.pc_en     = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: w_ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: w_ctrl.i_or_d = 1'b1;
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctrl.i_or_d    = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a   = 1'b1;
                w_ctrl.alu_src_b   = SRCB_REG;
                w_ctrl.alu_control = w_funct_alu;
            end
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a   = 1'b1;
                w_ctrl.alu_src_b   = SRCB_REG;
                w_ctrl.alu_control = ALU_SUB;
                w_ctrl.pc_src      = PCSRC_ALUOUT;
                w_ctrl.pc_en       = bus.zero ^ w_branch_inv;
            end
            S_ADDIWB: w_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                w_ctrl.pc_src = PCSRC_JUMP;
                w_ctrl.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset so an aborted instruction cannot commit anything.
    assign bus.pc_en       = w_ctrl.pc_en     & ~reset;
    assign bus.ir_write    = w_ctrl.ir_write  & ~reset;
    assign bus.mem_write   = w_ctrl.mem_write & ~reset;
    assign bus.reg_write   = w_ctrl.reg_write & ~reset;
    assign bus.i_or_d      = w_ctrl.i_or_d;
    assign bus.reg_dst     = w_ctrl.reg_dst;
    assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
    assign bus.alu_src_a   = w_ctrl.alu_src_a;
    assign bus.alu_src_b   = w_ctrl.alu_src_b;
    assign bus.pc_src      = w_ctrl.pc_src;
    assign bus.alu_control = w_ctrl.alu_control;
    assign bus.state       = r_state;
    assign bus.illegal     = r_illegal;
endmodule
